// File: rtl/timer_module_nch.sv
// Advanced timer: prescaled up/sawtooth or up-down counter with shadowed
// configuration, one-shot mode and N_CH compare/PWM channels with match events.
module timer_module_nch #(
    parameter int CNT_WIDTH   = 16,
    parameter int N_CH        = 4,
    parameter int N_EXTSIG    = 32,
    parameter int PRESC_WIDTH = 8
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
    input  logic                          cfg_start_i,
    input  logic                          cfg_stop_i,
    input  logic                          cfg_rst_i,
    input  logic                          cfg_update_i,
    input  logic                          cfg_oneshot_i,
    input  logic                          cfg_sawtooth_i,
    input  logic [2:0]                    cfg_mode_i,
    input  logic [$clog2(N_EXTSIG)-1:0]   cfg_sel_i,
    input  logic [PRESC_WIDTH-1:0]        cfg_presc_i,
    input  logic [CNT_WIDTH-1:0]          cfg_cnt_start_i,
    input  logic [CNT_WIDTH-1:0]          cfg_cnt_end_i,
    input  logic [N_CH*CNT_WIDTH-1:0]     cfg_comp_i,
    input  logic [N_CH*3-1:0]             cfg_comp_op_i,
    input  logic [N_EXTSIG-1:0]           signal_i,
    output logic [CNT_WIDTH-1:0]          counter_o,
    output logic [N_CH-1:0]               pwm_o,
    output logic [N_CH-1:0]               evt_o,
    output logic                          ovf_o,
    output logic                          running_o
);
    localparam int SEL_W = $clog2(N_EXTSIG);

    typedef enum logic {IDLE = 1'b0, RUN = 1'b1} state_t;

    state_t                     state_q, state_d;
    logic                       oneshot_q, oneshot_d;
    logic                       saw_q, saw_d;
    logic [2:0]                 mode_q, mode_d;
    logic [SEL_W-1:0]           sel_q, sel_d;
    logic [PRESC_WIDTH-1:0]     presc_q, presc_d;
    logic [CNT_WIDTH-1:0]       cnt_start_q, cnt_start_d;
    logic [CNT_WIDTH-1:0]       cnt_end_q, cnt_end_d;
    logic [N_CH*CNT_WIDTH-1:0]  comp_q, comp_d;
    logic [N_CH*3-1:0]          op_q, op_d;
    logic [PRESC_WIDTH-1:0]     pcnt_q, pcnt_d;
    logic [CNT_WIDTH-1:0]       cnt_q, cnt_d;
    logic                       dir_down_q, dir_down_d;
    logic                       pend_q, pend_d;
    logic [N_CH-1:0]            pwm_q, pwm_d;
    logic [N_CH-1:0]            evt_q, evt_d;
    logic                       ovf_q, ovf_d;
    logic [2:0]                 sync_q, sync_d;

    logic [CNT_WIDTH-1:0]       adv_cnt;
    logic                       adv_pe;
    logic                       adv_down;
    logic                       updown;
    logic [N_CH-1:0]            ch_pwm;
    logic [N_CH-1:0]            ch_evt;
    logic                       tick;
    logic                       start_go;
    logic                       load_cfg;

    // Counter value an advance would produce; out-of-range values snap to the
    // nearest period boundary so a reconfigured counter can never run away.
    always_comb begin
        updown   = !saw_q && (cnt_start_q < cnt_end_q);
        adv_cnt  = cnt_q + 1'b1;
        adv_pe   = 1'b0;
        adv_down = 1'b0;
        if (!updown) begin
            if (cnt_q >= cnt_end_q) begin
                adv_cnt = cnt_start_q;
                adv_pe  = 1'b1;
            end
        end else if (!dir_down_q) begin
            if (cnt_q >= cnt_end_q - 1'b1) begin
                adv_cnt  = cnt_end_q;
                adv_pe   = 1'b1;
                adv_down = 1'b1;
            end
        end else begin
            adv_down = 1'b1;
            adv_cnt  = cnt_q - 1'b1;
            if (cnt_q <= cnt_start_q + 1'b1) begin
                adv_cnt  = cnt_start_q;
                adv_pe   = 1'b1;
                adv_down = 1'b0;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
            logic [2:0] ch_op;
            logic       ch_hit;
            logic       pwm_nx;
            always_comb begin
                ch_op  = op_q[gi*3 +: 3];
                ch_hit = (adv_cnt == comp_q[gi*CNT_WIDTH +: CNT_WIDTH]);
                pwm_nx = pwm_q[gi];
                // End action first so a coincident match has the final say.
                if (adv_pe) begin
                    case (ch_op)
                        3'd1, 3'd2: pwm_nx = 1'b0;
                        3'd5, 3'd6: pwm_nx = 1'b1;
                        default:    pwm_nx = pwm_nx;
                    endcase
                end
                if (ch_hit) begin
                    case (ch_op)
                        3'd0, 3'd2:       pwm_nx = 1'b1;
                        3'd1, 3'd3, 3'd5: pwm_nx = ~pwm_nx;
                        3'd4, 3'd6:       pwm_nx = 1'b0;
                        default:          pwm_nx = pwm_nx;
                    endcase
                end
            end
            assign ch_pwm[gi] = pwm_nx;
            assign ch_evt[gi] = ch_hit;
        end
    endgenerate

    always_comb begin
        state_d     = state_q;
        oneshot_d   = oneshot_q;
        saw_d       = saw_q;
        mode_d      = mode_q;
        sel_d       = sel_q;
        presc_d     = presc_q;
        cnt_start_d = cnt_start_q;
        cnt_end_d   = cnt_end_q;
        comp_d      = comp_q;
        op_d        = op_q;
        pcnt_d      = pcnt_q;
        cnt_d       = cnt_q;
        dir_down_d  = dir_down_q;
        pend_d      = pend_q;
        pwm_d       = pwm_q;
        evt_d       = '0;
        ovf_d       = 1'b0;
        sync_d      = {sync_q[1:0], signal_i[sel_q]};
        load_cfg    = 1'b0;
        start_go    = (state_q == IDLE) && cfg_start_i && !cfg_stop_i;

        tick = 1'b0;
        case (mode_q)
            3'd0:    tick = 1'b1;
            3'd1:    tick = sync_q[1];
            3'd2:    tick = sync_q[1] & ~sync_q[2];
            3'd3:    tick = ~sync_q[1] & sync_q[2];
            3'd4:    tick = sync_q[1] ^ sync_q[2];
            default: tick = 1'b0;
        endcase

        if (cfg_update_i) begin
            if (state_q == IDLE) begin
                load_cfg = 1'b1;
                pend_d   = 1'b0;
            end else begin
                pend_d   = 1'b1;
            end
        end

        if ((state_q == RUN) && cfg_stop_i) begin
            state_d = IDLE;
        end else if (start_go) begin
            state_d    = RUN;
            load_cfg   = 1'b1;
            pend_d     = 1'b0;
            cnt_d      = cfg_cnt_start_i;
            pcnt_d     = '0;
            dir_down_d = 1'b0;
        end else if (cfg_rst_i) begin
            cnt_d      = cnt_start_q;
            pcnt_d     = '0;
            dir_down_d = 1'b0;
            pwm_d      = '0;
        end else if ((state_q == RUN) && tick) begin
            if (pcnt_q < presc_q) begin
                pcnt_d = pcnt_q + 1'b1;
            end else begin
                pcnt_d     = '0;
                cnt_d      = adv_cnt;
                dir_down_d = adv_down;
                pwm_d      = ch_pwm;
                evt_d      = ch_evt;
                ovf_d      = adv_pe;
                if (adv_pe && pend_q) begin
                    load_cfg = 1'b1;
                    pend_d   = 1'b0;
                end
                if (adv_pe && oneshot_q) begin
                    state_d = IDLE;
                    cnt_d   = cnt_start_q;
                end
            end
        end

        if (load_cfg) begin
            oneshot_d   = cfg_oneshot_i;
            saw_d       = cfg_sawtooth_i;
            mode_d      = cfg_mode_i;
            sel_d       = cfg_sel_i;
            presc_d     = cfg_presc_i;
            cnt_start_d = cfg_cnt_start_i;
            cnt_end_d   = cfg_cnt_end_i;
            comp_d      = cfg_comp_i;
            op_d        = cfg_comp_op_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            oneshot_q   <= 1'b0;
            saw_q       <= 1'b0;
            mode_q      <= '0;
            sel_q       <= '0;
            presc_q     <= '0;
            cnt_start_q <= '0;
            cnt_end_q   <= '0;
            comp_q      <= '0;
            op_q        <= '0;
            pcnt_q      <= '0;
            cnt_q       <= '0;
            dir_down_q  <= 1'b0;
            pend_q      <= 1'b0;
            pwm_q       <= '0;
            evt_q       <= '0;
            ovf_q       <= 1'b0;
            sync_q      <= '0;
        end else begin
            state_q     <= state_d;
            oneshot_q   <= oneshot_d;
            saw_q       <= saw_d;
            mode_q      <= mode_d;
            sel_q       <= sel_d;
            presc_q     <= presc_d;
            cnt_start_q <= cnt_start_d;
            cnt_end_q   <= cnt_end_d;
            comp_q      <= comp_d;
            op_q        <= op_d;
            pcnt_q      <= pcnt_d;
            cnt_q       <= cnt_d;
            dir_down_q  <= dir_down_d;
            pend_q      <= pend_d;
            pwm_q       <= pwm_d;
            evt_q       <= evt_d;
            ovf_q       <= ovf_d;
            sync_q      <= sync_d;
        end
    end

    assign counter_o = cnt_q;
    assign pwm_o     = pwm_q;
    assign evt_o     = evt_q;
    assign ovf_o     = ovf_q;
    assign running_o = (state_q == RUN);

endmodule

// File: tb/tb_timer_module_nch.sv
// Scoreboard bench for timer_module_nch: a behavioural model predicts each
// cycle's outputs at the clock edge, a negedge monitor pops and compares.
module tb_timer_module_nch;
    localparam int CW = 16;
    localparam int NC = 4;
    localparam int NE = 32;
    localparam int PW = 8;
    localparam int SW = $clog2(NE);

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic              cfg_start_i, cfg_stop_i, cfg_rst_i, cfg_update_i;
    logic              cfg_oneshot_i, cfg_sawtooth_i;
    logic [2:0]        cfg_mode_i;
    logic [SW-1:0]     cfg_sel_i;
    logic [PW-1:0]     cfg_presc_i;
    logic [CW-1:0]     cfg_cnt_start_i, cfg_cnt_end_i;
    logic [NC*CW-1:0]  cfg_comp_i;
    logic [NC*3-1:0]   cfg_comp_op_i;
    logic [NE-1:0]     signal_i;
    logic [CW-1:0]     counter_o;
    logic [NC-1:0]     pwm_o, evt_o;
    logic              ovf_o, running_o;

    always #5 clk_i = ~clk_i;

    timer_module_nch #(
        .CNT_WIDTH(CW), .N_CH(NC), .N_EXTSIG(NE), .PRESC_WIDTH(PW)
    ) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .cfg_start_i(cfg_start_i), .cfg_stop_i(cfg_stop_i), .cfg_rst_i(cfg_rst_i),
        .cfg_update_i(cfg_update_i), .cfg_oneshot_i(cfg_oneshot_i),
        .cfg_sawtooth_i(cfg_sawtooth_i), .cfg_mode_i(cfg_mode_i), .cfg_sel_i(cfg_sel_i),
        .cfg_presc_i(cfg_presc_i), .cfg_cnt_start_i(cfg_cnt_start_i),
        .cfg_cnt_end_i(cfg_cnt_end_i), .cfg_comp_i(cfg_comp_i),
        .cfg_comp_op_i(cfg_comp_op_i), .signal_i(signal_i),
        .counter_o(counter_o), .pwm_o(pwm_o), .evt_o(evt_o), .ovf_o(ovf_o),
        .running_o(running_o)
    );

    typedef struct packed {
        logic [CW-1:0] cnt;
        logic [NC-1:0] pwm;
        logic [NC-1:0] evt;
        logic          ovf;
        logic          run;
    } exp_t;

    exp_t exp_q[$];
    int   vectors     = 0;
    int   miscompares = 0;

    // Action codes: 0 clear, 1 set, 2 toggle, 3 leave alone
    int match_act[8] = '{1, 2, 1, 2, 0, 2, 0, 3};
    int end_act[8]   = '{3, 0, 0, 3, 3, 1, 1, 3};

    // Reference model state
    bit          m_run, m_down, m_pend, m_ovf;
    int          m_cnt, m_ticks;
    bit [NC-1:0] m_pwm, m_evt;
    bit          a_oneshot, a_saw;
    int          a_mode, a_sel, a_presc, a_start, a_end;
    int          a_comp[NC];
    int          a_op[NC];
    bit          samp[$];

    function automatic bit act(bit v, int code);
        case (code)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return ~v;
            default: return v;
        endcase
    endfunction

    task automatic model_reset();
        m_run = 0; m_down = 0; m_pend = 0; m_ovf = 0;
        m_cnt = 0; m_ticks = 0; m_pwm = '0; m_evt = '0;
        a_oneshot = 0; a_saw = 0; a_mode = 0; a_sel = 0; a_presc = 0;
        a_start = 0; a_end = 0;
        for (int c = 0; c < NC; c++) begin
            a_comp[c] = 0;
            a_op[c]   = 0;
        end
        samp.delete();
        repeat (3) samp.push_back(1'b0);
    endtask

    task automatic model_load();
        a_oneshot = cfg_oneshot_i;
        a_saw     = cfg_sawtooth_i;
        a_mode    = int'(cfg_mode_i);
        a_sel     = int'(cfg_sel_i);
        a_presc   = int'(cfg_presc_i);
        a_start   = int'(cfg_cnt_start_i);
        a_end     = int'(cfg_cnt_end_i);
        for (int c = 0; c < NC; c++) begin
            a_comp[c] = int'(cfg_comp_i[c*CW +: CW]);
            a_op[c]   = int'(cfg_comp_op_i[c*3 +: 3]);
        end
    endtask

    // One counter step along the period; returns 1 on a period-end step.
    function automatic bit model_advance();
        bit pe = 1'b0;
        if (a_saw || a_start >= a_end) begin
            m_down = 0;
            if (m_cnt >= a_end) begin
                m_cnt = a_start;
                pe    = 1'b1;
            end else begin
                m_cnt = (m_cnt + 1) % (1 << CW);
            end
        end else if (!m_down) begin
            m_cnt = (m_cnt + 1 > a_end) ? a_end : m_cnt + 1;
            if (m_cnt == a_end) begin
                pe     = 1'b1;
                m_down = 1;
            end
        end else begin
            m_cnt = (m_cnt - 1 < a_start) ? a_start : m_cnt - 1;
            if (m_cnt == a_start) begin
                pe     = 1'b1;
                m_down = 0;
            end
        end
        for (int c = 0; c < NC; c++) begin
            if (pe) m_pwm[c] = act(m_pwm[c], end_act[a_op[c]]);
            if (m_cnt == a_comp[c]) begin
                m_pwm[c] = act(m_pwm[c], match_act[a_op[c]]);
                m_evt[c] = 1'b1;
            end
        end
        m_ovf = pe;
        return pe;
    endfunction

    task automatic model_edge();
        bit lvl, prv, tick, load, pend_was, pe;
        if (rst_i) begin
            model_reset();
            return;
        end
        lvl = samp[1];
        prv = samp[0];
        case (a_mode)
            0:       tick = 1'b1;
            1:       tick = lvl;
            2:       tick = lvl & ~prv;
            3:       tick = ~lvl & prv;
            4:       tick = lvl ^ prv;
            default: tick = 1'b0;
        endcase
        samp.push_back(signal_i[a_sel]);
        void'(samp.pop_front());
        pend_was = m_pend;
        load     = 1'b0;
        m_evt    = '0;
        m_ovf    = 1'b0;
        if (cfg_update_i) begin
            if (!m_run) begin
                load   = 1'b1;
                m_pend = 1'b0;
            end else begin
                m_pend = 1'b1;
            end
        end
        if (m_run && cfg_stop_i) begin
            m_run = 0;
        end else if (!m_run && cfg_start_i && !cfg_stop_i) begin
            m_run = 1; load = 1'b1; m_pend = 0;
            m_cnt = int'(cfg_cnt_start_i); m_ticks = 0; m_down = 0;
        end else if (cfg_rst_i) begin
            m_cnt = a_start; m_ticks = 0; m_down = 0; m_pwm = '0;
        end else if (m_run && tick) begin
            if (m_ticks < a_presc) begin
                m_ticks++;
            end else begin
                m_ticks = 0;
                pe = model_advance();
                if (pe && pend_was) begin
                    load   = 1'b1;
                    m_pend = 0;
                end
                if (pe && a_oneshot) begin
                    m_run = 0;
                    m_cnt = a_start;
                end
            end
        end
        if (load) model_load();
    endtask

    task automatic cycle();
        exp_t e;
        @(posedge clk_i);
        model_edge();
        e.cnt = CW'(m_cnt);
        e.pwm = m_pwm;
        e.evt = m_evt;
        e.ovf = m_ovf;
        e.run = m_run;
        exp_q.push_back(e);
        #1;
        cfg_start_i  = 1'b0;
        cfg_stop_i   = 1'b0;
        cfg_rst_i    = 1'b0;
        cfg_update_i = 1'b0;
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic set_cfg(input bit os, input bit saw, input int mode, input int sel,
                           input int presc, input int st, input int en);
        cfg_oneshot_i   = os;
        cfg_sawtooth_i  = saw;
        cfg_mode_i      = 3'(mode);
        cfg_sel_i       = SW'(sel);
        cfg_presc_i     = PW'(presc);
        cfg_cnt_start_i = CW'(st);
        cfg_cnt_end_i   = CW'(en);
    endtask

    task automatic set_ch(input int c, input int comp, input int op);
        cfg_comp_i[c*CW +: CW] = CW'(comp);
        cfg_comp_op_i[c*3 +: 3] = 3'(op);
    endtask

    task automatic rand_cfg();
        int st;
        st = int'($urandom_range(0, 3));
        set_cfg(($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
                ($urandom_range(0, 1) == 1) ? 0 : int'($urandom_range(1, 7)),
                int'($urandom_range(0, NE-1)), int'($urandom_range(0, 2)),
                st, int'($urandom_range(st, 12)));
        for (int c = 0; c < NC; c++)
            set_ch(c, int'($urandom_range(0, 13)), int'($urandom_range(0, 7)));
    endtask

    always @(negedge clk_i) begin
        if (exp_q.size() > 0) begin
            exp_t e, a;
            e = exp_q.pop_front();
            a = {counter_o, pwm_o, evt_o, ovf_o, running_o};
            vectors++;
            if (a !== e) begin
                miscompares++;
                $display("FAIL outputs @%0t: got cnt=%0d pwm=%b evt=%b ovf=%b run=%b, want cnt=%0d pwm=%b evt=%b ovf=%b run=%b",
                         $time, a.cnt, a.pwm, a.evt, a.ovf, a.run,
                         e.cnt, e.pwm, e.evt, e.ovf, e.run);
            end
        end
    end

    initial begin
        rst_i = 1'b1;
        cfg_start_i = 0; cfg_stop_i = 0; cfg_rst_i = 0; cfg_update_i = 0;
        signal_i = '0;
        cfg_comp_i = '0;
        cfg_comp_op_i = '0;
        set_cfg(0, 0, 0, 0, 0, 0, 0);
        model_reset();
        run(2);
        rst_i = 1'b0;

        // Sawtooth 0..9, channel 0 set at 5 and cleared at period end
        set_cfg(0, 1, 0, 0, 0, 0, 9);
        set_ch(0, 5, 2);
        for (int c = 1; c < NC; c++) set_ch(c, 0, 7);
        cfg_start_i = 1'b1;
        run(25);
        $display("seg sawtooth 0..9 presc 0");

        // Up-down 2..5 with prescale 1
        cfg_stop_i = 1'b1;
        run(1);
        set_cfg(0, 0, 0, 0, 1, 2, 5);
        set_ch(1, 4, 3);
        cfg_start_i = 1'b1;
        run(24);
        $display("seg up-down 2..5 presc 1");

        // One-shot sawtooth 0..3
        cfg_stop_i = 1'b1;
        run(1);
        set_cfg(1, 1, 0, 0, 0, 0, 3);
        cfg_start_i = 1'b1;
        run(10);
        $display("seg oneshot 0..3");

        // Shadowed end change mid-period
        set_cfg(0, 1, 0, 0, 0, 0, 9);
        cfg_start_i = 1'b1;
        run(7);
        cfg_cnt_end_i = CW'(4);
        cfg_update_i  = 1'b1;
        run(20);
        $display("seg shadow update end 9->4");

        // Rising-edge ticks from signal 3, then start+stop together
        cfg_stop_i = 1'b1;
        run(1);
        signal_i = '0;
        set_cfg(0, 1, 2, 3, 0, 0, 9);
        cfg_start_i = 1'b1;
        run(4);
        for (int k = 0; k < 3; k++) begin
            signal_i[3] = ~signal_i[3];
            run(5);
        end
        cfg_stop_i = 1'b1;
        run(1);
        cfg_start_i = 1'b1;
        cfg_stop_i  = 1'b1;
        run(3);
        $display("seg rising edges on signal 3, start+stop");

        // Asynchronous reset mid-count, then restart
        set_cfg(0, 1, 0, 0, 0, 0, 9);
        set_ch(0, 2, 0);
        cfg_start_i = 1'b1;
        run(6);
        @(negedge clk_i);
        #1;
        rst_i = 1'b1;
        #1;
        vectors++;
        if ({counter_o, pwm_o, evt_o, ovf_o, running_o} !== '0) begin
            miscompares++;
            $display("FAIL async_reset: got cnt=%0d pwm=%b evt=%b ovf=%b run=%b, want all zero",
                     counter_o, pwm_o, evt_o, ovf_o, running_o);
        end
        run(2);
        rst_i = 1'b0;
        cfg_start_i = 1'b1;
        run(12);
        $display("seg async reset and restart");

        // Randomised segments
        for (int s = 0; s < 40; s++) begin
            cfg_stop_i = 1'b1;
            run(1);
            rand_cfg();
            cfg_start_i = 1'b1;
            for (int k = 0; k < 60; k++) begin
                if ($urandom_range(0, 2) == 0)  signal_i = $urandom();
                if ($urandom_range(0, 14) == 0) rand_cfg();
                if ($urandom_range(0, 14) == 0) cfg_update_i = 1'b1;
                if ($urandom_range(0, 39) == 0) cfg_stop_i = 1'b1;
                if ($urandom_range(0, 7) == 0)  cfg_start_i = 1'b1;
                if (!cfg_start_i && $urandom_range(0, 49) == 0) cfg_rst_i = 1'b1;
                cycle();
            end
            $display("seg random %0d mode=%0d saw=%0d start=%0d end=%0d presc=%0d",
                     s, a_mode, a_saw, a_start, a_end, a_presc);
        end

        @(negedge clk_i);
        #1;
        vectors++;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
